// File: rtl/priority_request_latch_4.sv
// Captures four request lines into sticky pending bits and issues the highest
// unmasked one (line 3 first) as a 2-bit code under a valid/ack handshake.
module priority_request_latch_4 #(
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic       Clock_In,
    input  logic       Reset_n_In,
    input  logic       Enable_In,
    input  logic       Request_0_In,
    input  logic       Request_1_In,
    input  logic       Request_2_In,
    input  logic       Request_3_In,
    input  logic [3:0] Mask_In,
    input  logic       Ack_In,
    input  logic       Clear_Overrun_In,
    output logic       Valid_Out,
    output logic [1:0] Encoded_Value_Out,
    output logic [3:0] Pending_Out,
    output logic [3:0] Overrun_Out
);

    typedef enum logic {IDLE, ISSUED} state_t;

    state_t     state, state_nxt;
    logic [3:0] req, req_q, evt, cand, clr_vec, ovr_set;
    logic [3:0] pending, overrun;
    logic [1:0] code, code_nxt, sel;
    logic       ack_fire;

    assign req  = {Request_3_In, Request_2_In, Request_1_In, Request_0_In};
    assign evt  = EDGE_DETECT ? (req & ~req_q) : req;
    assign cand = pending & ~Mask_In;

    always_comb begin
        sel = 2'd0;
        casez (cand)
            4'b1???: sel = 2'd3;
            4'b01??: sel = 2'd2;
            4'b001?: sel = 2'd1;
            default: sel = 2'd0;
        endcase
    end

    // Once issued, the code is frozen until acked; nothing can preempt it.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        ack_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (Enable_In && (cand != 4'd0)) begin
                    state_nxt = ISSUED;
                    code_nxt  = sel;
                end
            end
            ISSUED: begin
                if (Ack_In) begin
                    state_nxt = IDLE;
                    code_nxt  = 2'd0;
                    ack_fire  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                code_nxt  = 2'd0;
            end
        endcase
    end

    // A new event on the line being acked re-sets pending and is not an overrun.
    assign clr_vec = ack_fire ? (4'b0001 << code) : 4'd0;
    assign ovr_set = EDGE_DETECT ? (evt & pending & ~clr_vec) : 4'd0;

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state   <= IDLE;
            code    <= 2'd0;
            req_q   <= 4'd0;
            pending <= 4'd0;
            overrun <= 4'd0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            req_q   <= req;
            pending <= (pending & ~clr_vec) | evt;
            overrun <= (Clear_Overrun_In ? 4'd0 : overrun) | ovr_set;
        end
    end

    assign Valid_Out         = (state == ISSUED);
    assign Encoded_Value_Out = code;
    assign Pending_Out       = pending;
    assign Overrun_Out       = overrun;

endmodule

// File: tb/tb_priority_request_latch_4.sv
// Directed bench for priority_request_latch_4 (edge mode); expected output
// vectors go through a scoreboard queue and are checked #1 after each edge.
module tb_priority_request_latch_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       clr_ovr;
    logic       valid;
    logic [1:0] code;
    logic [3:0] pend;
    logic [3:0] ovr;

    typedef struct {
        string      tag;
        logic [10:0] vec;   // {valid, code, pending, overrun}
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    priority_request_latch_4 #(.EDGE_DETECT(1'b1)) dut (
        .Clock_In         (clk),
        .Reset_n_In       (rst_n),
        .Enable_In        (en),
        .Request_0_In     (req[0]),
        .Request_1_In     (req[1]),
        .Request_2_In     (req[2]),
        .Request_3_In     (req[3]),
        .Mask_In          (mask),
        .Ack_In           (ack),
        .Clear_Overrun_In (clr_ovr),
        .Valid_Out        (valid),
        .Encoded_Value_Out(code),
        .Pending_Out      (pend),
        .Overrun_Out      (ovr)
    );

    task automatic push_exp(input string tag, input logic v, input logic [1:0] c,
                            input logic [3:0] p, input logic [3:0] o);
        exp_t e;
        e.tag = tag;
        e.vec = {v, c, p, o};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [10:0] obs;
        e   = sb.pop_front();
        obs = {valid, code, pend, ovr};
        n_total++;
        assert (obs === e.vec) n_pass++;
        else $error("FAIL %s: observed v=%b c=%0d p=%b o=%b, expected v=%b c=%0d p=%b o=%b",
                    e.tag, obs[10], obs[9:8], obs[7:4], obs[3:0],
                    e.vec[10], e.vec[9:8], e.vec[7:4], e.vec[3:0]);
    endtask

    // Drive is already applied; expect values after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [1:0] c,
                        input logic [3:0] p, input logic [3:0] o);
        push_exp(tag, v, c, p, o);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 4'd0; mask = 4'd0; ack = 1'b0; clr_ovr = 1'b0;
        #2;
        push_exp("reset", 1'b0, 2'd0, 4'd0, 4'd0);
        pop_check();
        #10 rst_n = 1'b1;
        step("idle", 0, 0, 4'b0000, 4'b0000);

        // single pulse on line 2
        req = 4'b0100; step("t1_pend",  0, 0, 4'b0100, 0);
        req = 4'b0000; step("t1_issue", 1, 2, 4'b0100, 0);
        step("t1_hold", 1, 2, 4'b0100, 0);
        ack = 1; step("t1_ack", 0, 0, 4'b0000, 0);
        ack = 0;

        // lines 0,1,3 together: order 3,1,0 with bubbles
        req = 4'b1011; step("t2_pend", 0, 0, 4'b1011, 0);
        req = 4'b0000; step("t2_i3",   1, 3, 4'b1011, 0);
        ack = 1; step("t2_a3", 0, 0, 4'b0011, 0);
        ack = 0; step("t2_i1", 1, 1, 4'b0011, 0);
        ack = 1; step("t2_a1", 0, 0, 4'b0001, 0);
        ack = 0; step("t2_i0", 1, 0, 4'b0001, 0);
        ack = 1; step("t2_a0", 0, 0, 4'b0000, 0);
        ack = 0;

        // no preemption by higher priority arrival
        req = 4'b0010; step("t3_pend",   0, 0, 4'b0010, 0);
        req = 4'b0000; step("t3_i1",     1, 1, 4'b0010, 0);
        req = 4'b1000; step("t3_nopre",  1, 1, 4'b1010, 0);
        req = 4'b0000; step("t3_hold",   1, 1, 4'b1010, 0);
        ack = 1; step("t3_a1", 0, 0, 4'b1000, 0);
        ack = 0; step("t3_i3", 1, 3, 4'b1000, 0);
        ack = 1; step("t3_a3", 0, 0, 4'b0000, 0);
        ack = 0;

        // mask excludes line 3
        mask = 4'b1000;
        req = 4'b1001; step("t4_pend", 0, 0, 4'b1001, 0);
        req = 4'b0000; step("t4_i0",   1, 0, 4'b1001, 0);
        ack = 1; step("t4_a0", 0, 0, 4'b1000, 0);
        ack = 0; mask = 4'b0000; step("t4_i3", 1, 3, 4'b1000, 0);
        ack = 1; step("t4_a3", 0, 0, 4'b0000, 0);
        ack = 0;

        // overrun, clear, ack-vs-event, clear-vs-set
        req = 4'b0100; step("t5_pend", 0, 0, 4'b0100, 0);
        req = 4'b0000; step("t5_i2",   1, 2, 4'b0100, 0);
        req = 4'b0100; step("t5_ovr",  1, 2, 4'b0100, 4'b0100);
        req = 4'b0000; clr_ovr = 1; step("t5_clr", 1, 2, 4'b0100, 0);
        clr_ovr = 0; req = 4'b0100; ack = 1; step("t5_ackset", 0, 0, 4'b0100, 0);
        req = 4'b0000; ack = 0; step("t5_reissue", 1, 2, 4'b0100, 0);
        req = 4'b0100; clr_ovr = 1; step("t5_clrset", 1, 2, 4'b0100, 4'b0100);
        req = 4'b0000; step("t5_clr2", 1, 2, 4'b0100, 0);
        clr_ovr = 0; ack = 1; step("t5_a2", 0, 0, 4'b0000, 0);
        ack = 0;

        // enable freeze, ack while idle, async reset mid-issue
        en = 0;
        req = 4'b0010; step("t6_pend",   0, 0, 4'b0010, 0);
        req = 4'b0000; step("t6_frozen", 0, 0, 4'b0010, 0);
        ack = 1; step("t6_idleack", 0, 0, 4'b0010, 0);
        ack = 0; en = 1; step("t6_i1", 1, 1, 4'b0010, 0);
        #2 rst_n = 1'b0; req = 4'b0001;
        #1;
        push_exp("t6_async_rst", 0, 0, 4'b0000, 0);
        pop_check();

        // line 0 held high across reset release: one event only
        #3 rst_n = 1'b1;
        step("t7_relpend", 0, 0, 4'b0001, 0);
        step("t7_i0",      1, 0, 4'b0001, 0);
        ack = 1; step("t7_a0", 0, 0, 4'b0000, 0);
        ack = 0; step("t7_held", 0, 0, 4'b0000, 0);
        req = 4'b0000; step("t7_quiet", 0, 0, 4'b0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
